psram_arb: RTL and testbench
============================

PSRAM_ARB -- requirements
Module: psram_arb

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2: read access length in cycles (legal range 1..15).
REQ-002 SHALL have port clock  input  1  single clock for all state; every flop samples on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have, for each requester X in {m0, m1}: mX_valid in 1 (request pending); mX_write in 1 (1 = write); mX_addr in 24; mX_wdata in 32; mX_wmask in 4.
REQ-005 SHALL have, for each requester X: mX_ready out 1 (request accepted this cycle); mX_rvalid out 1 (response pulse); mX_rdata out 32.
REQ-006 SHALL have PSRAM side: ps_sel out 1; ps_write out 1; ps_addr out 24; ps_wdata out 32; ps_wmask out 4; ps_rdata in 32 (combinational read data).

Function
REQ-007 SHALL implement FSM states IDLE, ACCESS, RESP; transitions: IDLE->ACCESS on accept, ACCESS->RESP when access counter expires, RESP->IDLE unconditionally.
REQ-008 SHALL in IDLE grant at most one requester with mX_valid=1; granted mX_ready=1 for exactly one cycle; all other mX_ready=0.
REQ-009 SHALL, on accept, register write, addr, wdata, wmask and the granted requester ID; requesters hold request fields stable until ready.
REQ-010 SHALL for a read drive ps_sel=1, ps_write=0 for exactly WAIT_CYCLES consecutive ACCESS cycles, and capture ps_rdata on the final ACCESS cycle.
REQ-011 SHALL for a write stay in ACCESS WAIT_CYCLES cycles but drive ps_sel=1, ps_write=1 only on the final ACCESS cycle, producing exactly one PSRAM write.
REQ-012 SHALL drive ps_addr/ps_wdata/ps_wmask from registered request fields; all ps_* outputs 0 when ps_sel=0.
REQ-013 SHALL in RESP pulse mX_rvalid for the owning requester for one cycle; mX_rdata = captured data for reads, 0 for writes; mX_rdata 0 whenever mX_rvalid=0.
REQ-014 SHALL give latency: accept at cycle T, ACCESS T+1..T+WAIT_CYCLES, rvalid at T+WAIT_CYCLES+1; next accept no earlier than T+WAIT_CYCLES+2.
REQ-015 SHALL ignore mX_valid outside IDLE (no ready); new requests arriving during ACCESS/RESP wait.
REQ-016 SHALL with only one valid requester grant it regardless of arbitration state.
REQ-017 SHALL use a 4-bit access counter, loaded WAIT_CYCLES-1 at accept, decremented per ACCESS cycle, no wrap past 0.
REQ-018 SHALL accept a valid with wmask=0 as a normal write (one ps_sel cycle, wmask 0 forwarded).

Reset
REQ-019 SHALL on reset=0 immediately force state IDLE, counter 0, last-grant pointer to m1 (so m0 wins first), all outputs 0.
REQ-020 SHALL on reset mid-ACCESS abort the access with no rvalid and no PSRAM write after deassertion; requester reissues.
REQ-021 SHALL allow first accept on the first rising edge after reset deasserts.

Configuration
REQ-022 SHALL with PSRAM_ARB_RR_EN defined arbitrate round-robin: on simultaneous valid, grant the requester not granted last.
REQ-023 SHALL without PSRAM_ARB_RR_EN use fixed priority: m0 always wins simultaneous requests; pointer flop omitted.

Verification
REQ-024 SHALL cover: WAIT_CYCLES=2, m0 read addr 0x000100, model returns 0xDEADBEEF -> m0_ready at T, ps_sel high T+1..T+2, m0_rvalid with 0xDEADBEEF at T+3.
REQ-025 SHALL cover: m1 write addr 0x000040 data 0x12345678 mask 0xF -> exactly one ps_sel&ps_write cycle, readback 0x12345678, m1_rvalid rdata 0.
REQ-026 SHALL cover: m0 and m1 valid continuously, RR_EN defined -> grants m0,m1,m0,m1; undefined -> m0 only while m0 valid.
REQ-027 SHALL cover: reset asserted in second ACCESS cycle of a write -> ps_sel 0 same cycle, no rvalid, memory unchanged.
REQ-028 SHALL cover: WAIT_CYCLES=1 back-to-back reads -> rvalid at T+2, next accept at T+3.

Source files
------------

// File: rtl/psram_arb.sv
// psram_arb -- two-requester arbiter in front of a single-port PSRAM.
//
// One transaction at a time walks IDLE -> ACCESS -> RESP -> IDLE.
// A read holds ps_sel for WAIT_CYCLES cycles and samples ps_rdata on the
// last one. A write spends the same time in ACCESS but strobes ps_sel and
// ps_write only on the last cycle, so the part sees exactly one write.
//
// Ports
//   clock, reset                : clock; asynchronous active-low reset
//   mX_valid/write/addr/wdata/wmask : request from requester X (X = 0, 1)
//   mX_ready                    : request accepted this cycle
//   mX_rvalid, mX_rdata         : one-cycle response (rdata 0 for writes)
//   ps_sel/write/addr/wdata/wmask : PSRAM command (all zero when ps_sel=0)
//   ps_rdata                    : combinational PSRAM read data
//
// Build option
//   PSRAM_ARB_RR_EN : round-robin between simultaneous requests. When it is
//                     undefined m0 has fixed priority and the last-grant
//                     flop does not exist.
module psram_arb #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_write,
  input  logic [23:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  output logic        m0_ready,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_write,
  input  logic [23:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  output logic        m1_ready,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        ps_sel,
  output logic        ps_write,
  output logic [23:0] ps_addr,
  output logic [31:0] ps_wdata,
  output logic [3:0]  ps_wmask,
  input  logic [31:0] ps_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic        write;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state, state_nx;
  req_t        req_q;
  logic        id_q;       // owner of the transaction in flight (1 = m1)
  logic [3:0]  cnt_q;
  logic [31:0] rdata_q;

  logic gnt0, gnt1, accept, last_acc;

  // ---------------- arbitration ----------------
`ifdef PSRAM_ARB_RR_EN
  logic last_m1_q;   // reset to m1 so m0 wins the first contest

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      last_m1_q <= 1'b1;
    else if (accept) last_m1_q <= gnt1;
  end

  assign gnt0 = m0_valid & (~m1_valid | last_m1_q);
`else
  assign gnt0 = m0_valid;
`endif
  assign gnt1 = m1_valid & ~gnt0;

  assign accept   = (state == IDLE) & (gnt0 | gnt1);
  assign last_acc = (state == ACCESS) & (cnt_q == 4'd0);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)   state_nx = ACCESS;
      ACCESS:  if (last_acc) state_nx = RESP;
      RESP:                  state_nx = IDLE;
      default:               state_nx = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    m0_ready  = 1'b0;
    m1_ready  = 1'b0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    ps_sel    = 1'b0;
    ps_write  = 1'b0;
    ps_addr   = '0;
    ps_wdata  = '0;
    ps_wmask  = '0;
    case (state)
      IDLE: begin
        // ready is a function of the live valids; qualify with reset so
        // nothing is offered while the block is held in reset.
        m0_ready = reset & gnt0;
        m1_ready = reset & gnt1;
      end
      ACCESS: begin
        // reads occupy the bus the whole window; writes only on the last cycle
        ps_sel = ~req_q.write | last_acc;
        if (ps_sel) begin
          ps_write = req_q.write;
          ps_addr  = req_q.addr;
          ps_wdata = req_q.wdata;
          ps_wmask = req_q.wmask;
        end
      end
      RESP: begin
        m0_rvalid = ~id_q;
        m1_rvalid = id_q;
        if (!req_q.write) begin
          if (id_q) m1_rdata = rdata_q;
          else      m0_rdata = rdata_q;
        end
      end
      default: ;
    endcase
  end

  // ---------------- request capture / counter / read data ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_q   <= '0;
      id_q    <= 1'b0;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        id_q  <= gnt1;
        cnt_q <= CNT_LOAD;
        if (gnt1) req_q <= '{m1_write, m1_addr, m1_wdata, m1_wmask};
        else      req_q <= '{m0_write, m0_addr, m0_wdata, m0_wmask};
      end else if (state == ACCESS && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (last_acc && !req_q.write) rdata_q <= ps_rdata;
    end
  end

endmodule

// File: tb/tb_psram_arb.sv
module tb_psram_arb;

  localparam int W = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT A (WAIT_CYCLES = 2) ----------------
  logic        m0_valid, m0_write, m0_ready, m0_rvalid;
  logic [23:0] m0_addr;
  logic [31:0] m0_wdata, m0_rdata;
  logic [3:0]  m0_wmask;
  logic        m1_valid, m1_write, m1_ready, m1_rvalid;
  logic [23:0] m1_addr;
  logic [31:0] m1_wdata, m1_rdata;
  logic [3:0]  m1_wmask;
  logic        ps_sel, ps_write;
  logic [23:0] ps_addr;
  logic [31:0] ps_wdata, ps_rdata;
  logic [3:0]  ps_wmask;

  psram_arb #(.WAIT_CYCLES(W)) dut (
    .clock(clock), .reset(reset),
    .m0_valid(m0_valid), .m0_write(m0_write), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_ready(m0_ready),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_write(m1_write), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_ready(m1_ready),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ps_sel(ps_sel), .ps_write(ps_write), .ps_addr(ps_addr),
    .ps_wdata(ps_wdata), .ps_wmask(ps_wmask), .ps_rdata(ps_rdata)
  );

  // PSRAM model: word array, combinational read, byte-masked write
  logic [31:0] mem [0:1023];
  assign ps_rdata = mem[ps_addr[11:2]];
  always @(posedge clock)
    if (ps_sel && ps_write)
      for (int b = 0; b < 4; b++)
        if (ps_wmask[b]) mem[ps_addr[11:2]][8*b +: 8] <= ps_wdata[8*b +: 8];

  // ---------------- DUT B (WAIT_CYCLES = 1) ----------------
  logic        b_m0_valid, b_m0_ready, b_m0_rvalid, b_m1_ready, b_m1_rvalid;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_ps_wdata, b_ps_rdata;
  logic        b_ps_sel, b_ps_write;
  logic [23:0] b_ps_addr;
  logic [3:0]  b_ps_wmask;

  assign b_ps_rdata = {8'hA5, b_ps_addr};

  psram_arb #(.WAIT_CYCLES(1)) dut_b (
    .clock(clock), .reset(reset),
    .m0_valid(b_m0_valid), .m0_write(1'b0), .m0_addr(24'h000123),
    .m0_wdata(32'h0), .m0_wmask(4'h0), .m0_ready(b_m0_ready),
    .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
    .m1_valid(1'b0), .m1_write(1'b0), .m1_addr(24'h0),
    .m1_wdata(32'h0), .m1_wmask(4'h0), .m1_ready(b_m1_ready),
    .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
    .ps_sel(b_ps_sel), .ps_write(b_ps_write), .ps_addr(b_ps_addr),
    .ps_wdata(b_ps_wdata), .ps_wmask(b_ps_wmask), .ps_rdata(b_ps_rdata)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic        id;
    logic        wr;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sbq[$];

  // ---------------- monitor A: scoreboard pop + bus rules ----------------
  int          sel_n = 0, wr_n = 0;
  logic [3:0]  last_wmask = 4'hx;

  always @(negedge clock) begin
    exp_t e;
    if (m0_ready || m1_ready) begin sel_n = 0; wr_n = 0; end
    if (ps_sel) begin
      sel_n++;
      if (ps_write) begin wr_n++; last_wmask = ps_wmask; end
    end
    if (!ps_sel && (ps_write || ps_addr != 0 || ps_wdata != 0 || ps_wmask != 0))
      chk("ps_idle_zero", 32'(1), 32'(0));
    if (m0_ready && m1_ready) chk("dual_ready", 32'(1), 32'(0));
    if (!m0_rvalid && m0_rdata != 0) chk("m0_rdata_idle", m0_rdata, 32'h0);
    if (!m1_rvalid && m1_rdata != 0) chk("m1_rdata_idle", m1_rdata, 32'h0);
    if (m0_rvalid || m1_rvalid) begin
      if (sbq.size() == 0) chk("unexp_rvalid", 32'(1), 32'(0));
      else begin
        e = sbq.pop_front();
        chk("rv_owner", {30'h0, m1_rvalid, m0_rvalid}, e.id ? 32'h2 : 32'h1);
        chk("rv_data", e.id ? m1_rdata : m0_rdata, e.data);
        chk("rv_cycle", 32'(cyc), 32'(e.due));
        chk("sel_cycles", 32'(sel_n), e.wr ? 32'(1) : 32'(W));
        chk("write_cycles", 32'(wr_n), e.wr ? 32'(1) : 32'(0));
      end
    end
  end

  // ---------------- monitor B: timestamps ----------------
  int brdy[$];
  int brv[$];
  always @(negedge clock) begin
    if (b_m0_ready) brdy.push_back(cyc);
    if (b_m0_rvalid) begin
      brv.push_back(cyc);
      chk("b_rdata", b_m0_rdata, 32'hA5000123);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic id, input logic v, input logic wr,
                       input logic [23:0] a, input logic [31:0] wd, input logic [3:0] wm);
    if (id) begin m1_valid = v; m1_write = wr; m1_addr = a; m1_wdata = wd; m1_wmask = wm; end
    else    begin m0_valid = v; m0_write = wr; m0_addr = a; m0_wdata = wd; m0_wmask = wm; end
  endtask

  // Issue one request, wait for its ready, push the expected response.
  task automatic do_req(input logic id, input logic wr, input logic [23:0] a,
                        input logic [31:0] wd, input logic [3:0] wm, input logic [31:0] exp);
    int n = 0;
    exp_t e;
    @(posedge clock); #1;
    drive(id, 1'b1, wr, a, wd, wm);
    do begin @(negedge clock); n++; end
    while (!(id ? m1_ready : m0_ready) && n < 50);
    if (!(id ? m1_ready : m0_ready)) chk("accept_timeout", 32'(0), 32'(1));
    else begin
      e.id = id; e.wr = wr; e.data = wr ? 32'h0 : exp; e.due = cyc + W + 1;
      sbq.push_back(e);
    end
    @(posedge clock); #1;
    drive(id, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin @(negedge clock); n++; end
    chk("drain", 32'(sbq.size()), 32'(0));
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic gid;
    exp_t e;
    logic [31:0] gexp [0:3];

    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[24'h000100 >> 2] = 32'hDEADBEEF;
    mem[24'h000080 >> 2] = 32'hCAFEF00D;
    drive(1'b0, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
    b_m0_valid = 1'b0;

    // reset: a pending read must not be offered ready; outputs quiet
    drive(1'b0, 1'b1, 1'b0, 24'h000100, 32'h0, 4'h0);
    repeat (2) @(negedge clock);
    chk("rst_m0_ready", 32'(m0_ready), 32'(0));
    chk("rst_ps_sel", 32'(ps_sel), 32'(0));
    chk("rst_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'(0));

    // first accept in the first cycle after release; m0 read of 0xDEADBEEF
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock);
    chk("first_accept", 32'(m0_ready), 32'(1));
    if (m0_ready) begin
      e.id = 1'b0; e.wr = 1'b0; e.data = 32'hDEADBEEF; e.due = cyc + W + 1;
      sbq.push_back(e);
    end
    @(posedge clock); #1 drive(1'b0, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
    wait_idle();

    // m1 full write, then read it back through m0
    do_req(1'b1, 1'b1, 24'h000040, 32'h12345678, 4'hF, 32'h0);
    wait_idle();
    chk("mem_0x40", mem[24'h000040 >> 2], 32'h12345678);
    do_req(1'b0, 1'b0, 24'h000040, 32'h0, 4'h0, 32'h12345678);
    wait_idle();

    // partial byte mask
    do_req(1'b0, 1'b1, 24'h000040, 32'hAABBCCDD, 4'h3, 32'h0);
    wait_idle();
    do_req(1'b0, 1'b0, 24'h000040, 32'h0, 4'h0, 32'h1234CCDD);
    wait_idle();

    // wmask=0 write still makes one bus write, data untouched
    do_req(1'b1, 1'b1, 24'h000080, 32'hFFFFFFFF, 4'h0, 32'h0);
    wait_idle();
    chk("wmask0_fwd", 32'(last_wmask), 32'(0));
    do_req(1'b1, 1'b0, 24'h000080, 32'h0, 4'h0, 32'hCAFEF00D);
    wait_idle();

    // contention: both valid continuously; last grant was m1
`ifdef PSRAM_ARB_RR_EN
    gexp[0] = 0; gexp[1] = 1; gexp[2] = 0; gexp[3] = 1;
`else
    gexp[0] = 0; gexp[1] = 0; gexp[2] = 0; gexp[3] = 0;
`endif
    @(posedge clock); #1;
    drive(1'b0, 1'b1, 1'b0, 24'h000100, 32'h0, 4'h0);
    drive(1'b1, 1'b1, 1'b0, 24'h000080, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin @(negedge clock); n++; end
      while (!(m0_ready || m1_ready) && n < 20);
      if (!(m0_ready || m1_ready)) chk("arb_timeout", 32'(0), 32'(1));
      else begin
        gid = m1_ready;
        chk($sformatf("grant%0d", k), 32'(gid), gexp[k]);
        e.id = gid; e.wr = 1'b0; e.data = gid ? 32'hCAFEF00D : 32'hDEADBEEF;
        e.due = cyc + W + 1;
        sbq.push_back(e);
      end
    end
    @(posedge clock); #1;
    drive(1'b0, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
    wait_idle();

    // reset during the second ACCESS cycle of a write aborts it
    @(posedge clock); #1;
    drive(1'b1, 1'b1, 1'b1, 24'h000200, 32'h00000055, 4'hF);
    n = 0;
    do begin @(negedge clock); n++; end
    while (!m1_ready && n < 20);
    chk("abort_accept", 32'(m1_ready), 32'(1));
    @(posedge clock); #1 drive(1'b1, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("abort_ps_sel", 32'(ps_sel), 32'(0));
    chk("abort_ps_write", 32'(ps_write), 32'(0));
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    repeat (6) @(negedge clock);
    chk("abort_mem", mem[24'h000200 >> 2], 32'h0);
    do_req(1'b1, 1'b1, 24'h000200, 32'h00000055, 4'hF, 32'h0);
    wait_idle();
    chk("reissue_mem", mem[24'h000200 >> 2], 32'h00000055);

    // WAIT_CYCLES=1: back-to-back reads
    @(posedge clock); #1 b_m0_valid = 1'b1;
    repeat (9) @(negedge clock);
    @(posedge clock); #1 b_m0_valid = 1'b0;
    repeat (4) @(negedge clock);
    chk("b_accepts", 32'(brdy.size()), 32'(3));
    chk("b_resps", 32'(brv.size()), 32'(3));
    if (brdy.size() >= 2 && brv.size() >= 2) begin
      chk("b_rv_lat0", 32'(brv[0] - brdy[0]), 32'(2));
      chk("b_next_acc", 32'(brdy[1] - brdy[0]), 32'(3));
      chk("b_rv_lat1", 32'(brv[1] - brdy[1]), 32'(2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
